// File: rtl/cpu_data_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_data_bridge_if
//  Purpose  : CPU data-port handshake bundle between the core and the
//             cpu_data_bridge. One transaction at a time: the core holds
//             request/address/write/wstrb/wdata until ack, and rdata is
//             valid only while ack is high.
//  Signals  : request  - transaction request (core -> bridge)
//             address  - 32-bit byte address (core -> bridge)
//             write    - 1 = store, 0 = load (core -> bridge)
//             wstrb    - store byte enables (core -> bridge)
//             wdata    - store data (core -> bridge)
//             rdata    - load data (bridge -> core)
//             ack      - one-cycle completion pulse (bridge -> core)
//  Modports : master - the CPU core side
//             slave  - the bridge side
//  Revision : 1.0 - initial release
// ============================================================================
interface cpu_data_bridge_if;
    logic        request;
    logic [31:0] address;
    logic        write;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output request,
        output address,
        output write,
        output wstrb,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  request,
        input  address,
        input  write,
        input  wstrb,
        input  wdata,
        output rdata,
        output ack
    );
endinterface
`default_nettype wire

// File: rtl/cpu_data_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_data_bridge
//  Purpose  : Data-side bridge directly behind the CPU data port. Decodes
//             each access into on-chip RAM (0x0000_xxxx), the peripheral bus
//             (0xE000_xxxx) or unmapped space. Peripheral accesses are
//             guarded by a timeout so the core can never hang; unmapped and
//             timed-out accesses complete with bus_error.
//  Ports    : clock, reset      - clock / asynchronous active-high reset
//             cpu               - CPU handshake (slave side of the interface)
//             ram_en, ram_we    - RAM port enable / write enable
//             ram_addr          - RAM word address
//             ram_wstrb/wdata   - RAM store strobes / data (pass-through)
//             ram_rdata         - RAM read data, one cycle after ram_en
//             per_request       - peripheral request, held until ack/timeout
//             per_address/write/wstrb/wdata - registered access fields
//             per_rdata, per_ack - peripheral reply
//             bus_error         - pulses with an error completion
//             error_address     - address of the last errored access
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_data_bridge #(
    parameter int RAM_ADDR_BITS  = 14,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic                     clock,
    input  wire logic                     reset,

    cpu_data_bridge_if.slave              cpu,

    output logic                          ram_en,
    output logic                          ram_we,
    output logic [RAM_ADDR_BITS-1:0]      ram_addr,
    output logic [3:0]                    ram_wstrb,
    output logic [31:0]                   ram_wdata,
    input  wire logic [31:0]              ram_rdata,

    output logic                          per_request,
    output logic [31:0]                   per_address,
    output logic                          per_write,
    output logic [3:0]                    per_wstrb,
    output logic [31:0]                   per_wdata,
    input  wire logic [31:0]              per_rdata,
    input  wire logic                     per_ack,

    output logic                          bus_error,
    output logic [31:0]                   error_address
);

    // ------------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------------
    localparam logic [15:0] c_ram_region = 16'h0000;
    localparam logic [15:0] c_per_region = 16'hE000;
    localparam logic [7:0]  c_timeout    = 8'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RAM_WAIT = 3'd1,
        S_PER_WAIT = 3'd2,
        S_PER_DONE = 3'd3,
        S_ERR      = 3'd4
    } state_t;

    state_t      r_state;
    logic [7:0]  r_count;      // cycles spent in PER_WAIT
    logic        r_ram_load;   // current RAM access is a load
    logic        r_ack;
    logic        r_bus_error;
    logic [31:0] r_rdata;      // captured peripheral data, zero otherwise

    logic        w_is_ram;
    logic        w_is_per;
    logic        w_start;
    logic [7:0]  w_count_next;

    // Byte-lane bits never select a RAM word; the name marks them as
    // intentionally unconsumed.
    logic        w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^cpu.address[1:0];

    // ------------------------------------------------------------------------
    // Address decode and RAM port. The RAM sees the access in the same cycle
    // the request is accepted so its registered read data lands exactly in
    // RAM_WAIT, giving a fixed one-cycle load latency.
    // ------------------------------------------------------------------------
    assign w_is_ram     = (cpu.address[31:16] == c_ram_region);
    assign w_is_per     = (cpu.address[31:16] == c_per_region);
    assign w_start      = (r_state == S_IDLE) && cpu.request;
    assign w_count_next = r_count + 8'd1;

    assign ram_en    = w_start && w_is_ram;
    assign ram_we    = ram_en && cpu.write;
    assign ram_addr  = cpu.address[RAM_ADDR_BITS+1:2];
    assign ram_wstrb = cpu.wstrb;
    assign ram_wdata = cpu.wdata;

    // ------------------------------------------------------------------------
    // CPU return path. ack/bus_error are registered; read data is muxed so
    // that the RAM's own output register feeds the core without an extra
    // cycle. Everything else (stores, errors, idle) reads back as zero.
    // ------------------------------------------------------------------------
    assign cpu.ack   = r_ack;
    assign bus_error = r_bus_error;
    assign cpu.rdata = ((r_state == S_RAM_WAIT) && r_ram_load) ? ram_rdata : r_rdata;

    // ------------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_count       <= 8'd0;
            r_ram_load    <= 1'b0;
            r_ack         <= 1'b0;
            r_bus_error   <= 1'b0;
            r_rdata       <= 32'd0;
            per_request   <= 1'b0;
            per_address   <= 32'd0;
            per_write     <= 1'b0;
            per_wstrb     <= 4'd0;
            per_wdata     <= 32'd0;
            error_address <= 32'd0;
        end else begin
            // Completion flags and captured data are single-cycle pulses.
            r_ack       <= 1'b0;
            r_bus_error <= 1'b0;
            r_rdata     <= 32'd0;

            case (r_state)
                S_IDLE: begin
                    if (cpu.request) begin
                        if (w_is_ram) begin
                            r_ram_load <= ~cpu.write;
                            r_ack      <= 1'b1;
                            r_state    <= S_RAM_WAIT;
                        end else if (w_is_per) begin
                            per_address <= cpu.address;
                            per_write   <= cpu.write;
                            per_wstrb   <= cpu.wstrb;
                            per_wdata   <= cpu.wdata;
                            per_request <= 1'b1;
                            r_count     <= 8'd0;
                            r_state     <= S_PER_WAIT;
                        end else begin
                            error_address <= cpu.address;
                            r_ack         <= 1'b1;
                            r_bus_error   <= 1'b1;
                            r_state       <= S_ERR;
                        end
                    end
                end

                S_RAM_WAIT: begin
                    r_state <= S_IDLE;
                end

                S_PER_WAIT: begin
                    r_count <= w_count_next;
                    // A reply arriving on the last allowed cycle still counts
                    // as success, so it is tested before the timeout.
                    if (per_ack) begin
                        per_request <= 1'b0;
                        r_rdata     <= per_rdata;
                        r_ack       <= 1'b1;
                        r_state     <= S_PER_DONE;
                    end else if (w_count_next == c_timeout) begin
                        per_request   <= 1'b0;
                        error_address <= per_address;
                        r_ack         <= 1'b1;
                        r_bus_error   <= 1'b1;
                        r_state       <= S_ERR;
                    end
                end

                S_PER_DONE: begin
                    r_state <= S_IDLE;
                end

                S_ERR: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    per_request <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_data_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_data_bridge
//  Purpose  : Directed self-checking bench for cpu_data_bridge: RAM store /
//             load, back-to-back loads, peripheral load, peripheral timeout
//             with a late reply, unmapped access and reset during PER_WAIT.
//             Inputs change on the falling edge; outputs are sampled there.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_data_bridge;

    localparam int RAM_ADDR_BITS  = 14;
    localparam int TIMEOUT_CYCLES = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    cpu_data_bridge_if cpu_bus ();

    logic                     ram_en;
    logic                     ram_we;
    logic [RAM_ADDR_BITS-1:0] ram_addr;
    logic [3:0]               ram_wstrb;
    logic [31:0]              ram_wdata;
    logic [31:0]              ram_rdata;
    logic                     per_request;
    logic [31:0]              per_address;
    logic                     per_write;
    logic [3:0]               per_wstrb;
    logic [31:0]              per_wdata;
    logic [31:0]              per_rdata;
    logic                     per_ack;
    logic                     bus_error;
    logic [31:0]              error_address;

    cpu_data_bridge #(
        .RAM_ADDR_BITS  (RAM_ADDR_BITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu           (cpu_bus),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wstrb     (ram_wstrb),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .per_request   (per_request),
        .per_address   (per_address),
        .per_write     (per_write),
        .per_wstrb     (per_wstrb),
        .per_wdata     (per_wdata),
        .per_rdata     (per_rdata),
        .per_ack       (per_ack),
        .bus_error     (bus_error),
        .error_address (error_address)
    );

    // Synchronous RAM model: byte-masked write, read-before-write, 1 cycle.
    logic [31:0] mem [0:(1<<RAM_ADDR_BITS)-1];
    always @(posedge clock) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we && ram_wstrb[b])
                    mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One RAM access starting at a falling edge with the bridge in IDLE.
    // Returns at the falling edge after the ack cycle (bridge in IDLE again),
    // with the request still asserted so a following call is back-to-back.
    task automatic ram_xfer(input logic [31:0] addr, input logic wr,
                            input logic [31:0] data, input logic [31:0] exp_rd);
        logic [31:0] exp_word;
        exp_word             = (addr >> 2) & 32'h3FFF;
        cpu_bus.request      = 1'b1;
        cpu_bus.address      = addr;
        cpu_bus.write        = wr;
        cpu_bus.wstrb        = 4'hF;
        cpu_bus.wdata        = data;
        #1;
        chk("ram_en_req",  32'(ram_en), 1);
        chk("ram_we_req",  32'(ram_we), 32'(wr));
        chk("ram_addr",    32'(ram_addr), exp_word);
        chk("ack_early",   32'(cpu_bus.ack), 0);
        @(negedge clock);
        chk("ram_ack",     32'(cpu_bus.ack), 1);
        chk("ram_no_err",  32'(bus_error), 0);
        chk("ram_rdata",   cpu_bus.rdata, exp_rd);
        chk("ram_we_ack",  32'(ram_we), 0);
        @(negedge clock);
    endtask

    int  cnt;
    int  cycles;
    logic seen;

    initial begin
        cpu_bus.request = 1'b0;
        cpu_bus.address = 32'd0;
        cpu_bus.write   = 1'b0;
        cpu_bus.wstrb   = 4'd0;
        cpu_bus.wdata   = 32'd0;
        per_rdata       = 32'd0;
        per_ack         = 1'b0;

        // ---- reset state ---------------------------------------------------
        @(negedge clock);
        chk("rst_ack",      32'(cpu_bus.ack), 0);
        chk("rst_berr",     32'(bus_error), 0);
        chk("rst_per_req",  32'(per_request), 0);
        chk("rst_rdata",    cpu_bus.rdata, 0);
        chk("rst_err_addr", error_address, 0);
        chk("rst_per_addr", per_address, 0);
        chk("rst_ram_en",   32'(ram_en), 0);
        reset = 1'b0;
        @(negedge clock);

        // ---- RAM store then load --------------------------------------------
        ram_xfer(32'h0000_0010, 1'b1, 32'hCAFE_BABE, 32'h0);
        ram_xfer(32'h0000_0010, 1'b0, 32'h0,         32'hCAFE_BABE);
        ram_xfer(32'h0000_0020, 1'b1, 32'h1122_3344, 32'h0);
        ram_xfer(32'h0000_0024, 1'b1, 32'h5566_7788, 32'h0);
        cpu_bus.request = 1'b0;
        @(negedge clock);

        // ---- back-to-back loads, request held throughout ---------------------
        ram_xfer(32'h0000_0020, 1'b0, 32'h0, 32'h1122_3344);
        ram_xfer(32'h0000_0024, 1'b0, 32'h0, 32'h5566_7788);
        ram_xfer(32'h0000_0010, 1'b0, 32'h0, 32'hCAFE_BABE);
        cpu_bus.request = 1'b0;
        @(negedge clock);

        // ---- peripheral load, ack on 3rd per_request cycle -------------------
        cpu_bus.request = 1'b1;
        cpu_bus.address = 32'hE000_0004;
        cpu_bus.write   = 1'b0;
        #1;
        chk("per_ram_en",  32'(ram_en), 0);
        chk("per_req_n",   32'(per_request), 0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (per_request) cnt++;
            chk("per_wait_ack", 32'(cpu_bus.ack), 0);
            if (i == 2) begin
                per_ack   = 1'b1;
                per_rdata = 32'h1234_5678;
            end
        end
        chk("per_addr",   per_address, 32'hE000_0004);
        @(negedge clock);
        per_ack   = 1'b0;
        per_rdata = 32'd0;
        chk("per_req_cnt", cnt, 3);
        chk("per_ack",     32'(cpu_bus.ack), 1);
        chk("per_rdata",   cpu_bus.rdata, 32'h1234_5678);
        chk("per_berr",    32'(bus_error), 0);
        chk("per_req_off", 32'(per_request), 0);
        @(negedge clock);
        cpu_bus.request = 1'b0;
        @(negedge clock);

        // ---- peripheral timeout, then late reply -----------------------------
        cpu_bus.request = 1'b1;
        cpu_bus.address = 32'hE000_0008;
        cpu_bus.write   = 1'b0;
        cnt = 0; cycles = 0; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            cycles++;
            if (cpu_bus.ack) begin
                seen = 1'b1;
                break;
            end
            if (per_request) cnt++;
        end
        chk("to_ack_seen",  32'(seen), 1);
        chk("to_latency",   cycles, TIMEOUT_CYCLES + 1);
        chk("to_req_cnt",   cnt, TIMEOUT_CYCLES);
        chk("to_berr",      32'(bus_error), 1);
        chk("to_rdata",     cpu_bus.rdata, 0);
        chk("to_err_addr",  error_address, 32'hE000_0008);
        chk("to_req_off",   32'(per_request), 0);
        @(negedge clock);
        cpu_bus.request = 1'b0;
        @(negedge clock);
        per_ack   = 1'b1;
        per_rdata = 32'hDEAD_BEEF;
        #1;
        chk("late_ack0",    32'(cpu_bus.ack), 0);
        @(negedge clock);
        per_ack = 1'b0;
        chk("late_ack1",    32'(cpu_bus.ack), 0);
        chk("late_berr",    32'(bus_error), 0);
        chk("late_req",     32'(per_request), 0);
        @(negedge clock);

        // ---- unmapped access -------------------------------------------------
        cpu_bus.request = 1'b1;
        cpu_bus.address = 32'h4000_0000;
        cpu_bus.write   = 1'b0;
        #1;
        chk("um_ram_en",    32'(ram_en), 0);
        chk("um_ack_early", 32'(cpu_bus.ack), 0);
        @(negedge clock);
        chk("um_ack",       32'(cpu_bus.ack), 1);
        chk("um_berr",      32'(bus_error), 1);
        chk("um_rdata",     cpu_bus.rdata, 0);
        chk("um_err_addr",  error_address, 32'h4000_0000);
        chk("um_per_req",   32'(per_request), 0);
        @(negedge clock);
        cpu_bus.request = 1'b0;
        chk("um_berr_off",  32'(bus_error), 0);
        @(negedge clock);

        // ---- reset while in PER_WAIT -----------------------------------------
        cpu_bus.request = 1'b1;
        cpu_bus.address = 32'hE000_0010;
        cpu_bus.write   = 1'b1;
        cpu_bus.wdata   = 32'h0000_0055;
        @(negedge clock);
        chk("rw_per_req",   32'(per_request), 1);
        chk("rw_per_write", 32'(per_write), 1);
        chk("rw_per_wdata", per_wdata, 32'h0000_0055);
        #2;
        reset = 1'b1;
        #1;
        chk("rw_req_drop",  32'(per_request), 0);
        chk("rw_per_addr",  per_address, 0);
        cpu_bus.request = 1'b0;
        cpu_bus.write   = 1'b0;
        @(negedge clock);
        chk("rw_no_ack0",   32'(cpu_bus.ack), 0);
        reset = 1'b0;
        @(negedge clock);
        chk("rw_no_ack1",   32'(cpu_bus.ack), 0);
        chk("rw_req_low",   32'(per_request), 0);
        ram_xfer(32'h0000_0010, 1'b0, 32'h0, 32'hCAFE_BABE);
        cpu_bus.request = 1'b0;
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/cpu_data_bridge.md
# cpu_data_bridge

Data-side bus bridge sitting directly downstream of the CPU core's data port. Accepts one load/store at a time on the `cpu_*` handshake, decodes the address into on-chip RAM, the peripheral bus or unmapped space, and returns `cpu_ack`/`cpu_rdata` with fixed or handshake-dependent latency. Peripheral accesses are protected by a timeout counter; unmapped and timed-out accesses complete with an error flag so the core never hangs.

## Interface
- `RAM_ADDR_BITS`, 14: RAM word-address width (2^14 words = 64 KB).
- `TIMEOUT_CYCLES`, 255: max cycles `per_request` waits for `per_ack` (1..255, 8-bit counter).
- `clock`  in  1  single clock, all state rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_request`  in  1  transaction request, held with address/data until `cpu_ack`.
- `cpu_address`  in  32  byte address; bits [1:0] ignored for RAM word select.
- `cpu_write`  in  1  1 = store, 0 = load.
- `cpu_wstrb`  in  4  byte enables for stores.
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data, valid only while `cpu_ack`=1.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `ram_en`, `ram_we`  out  1,1  RAM port enable / write enable.
- `ram_addr`  out  RAM_ADDR_BITS  word address = `cpu_address[RAM_ADDR_BITS+1:2]`.
- `ram_wstrb`, `ram_wdata`  out  4, 32  pass-through of `cpu_wstrb`/`cpu_wdata`.
- `ram_rdata`  in  32  synchronous RAM read data, 1-cycle latency.
- `per_request`  out  1  peripheral request, held until `per_ack` or timeout.
- `per_address`, `per_write`, `per_wstrb`, `per_wdata`  out  32,1,4,32  registered copies of the cpu fields.
- `per_rdata`  in  32  peripheral read data, valid with `per_ack`.
- `per_ack`  in  1  peripheral completion pulse.
- `bus_error`  out  1  one-cycle pulse coincident with an error `cpu_ack`.
- `error_address`  out  32  address of the most recent errored access (holds until next error).

## Operation
- Region decode on `cpu_address[31:16]`: 0x0000 → RAM; 0xE000 → peripheral; anything else → unmapped.
- States: IDLE, RAM_WAIT, PER_WAIT, PER_DONE, ERR.
- IDLE & request & RAM: drive `ram_en`=1, `ram_we`=`cpu_write` combinationally this cycle; → RAM_WAIT.
- RAM_WAIT: `cpu_ack`=1, `cpu_rdata`=`ram_rdata` (loads; stores return 0); → IDLE.
- IDLE & request & peripheral: register `per_*` fields, clear timeout counter; → PER_WAIT.
- PER_WAIT: `per_request`=1; counter increments each cycle. On `per_ack`: capture `per_rdata` → PER_DONE. Else if counter reaches `TIMEOUT_CYCLES`: drop `per_request`, latch `error_address` → ERR. `per_ack` wins if it arrives on the timeout cycle.
- PER_DONE: `cpu_ack`=1, `cpu_rdata`=captured data; → IDLE.
- IDLE & request & unmapped: latch `error_address`; → ERR (no RAM/peripheral activity).
- ERR: `cpu_ack`=1, `bus_error`=1, `cpu_rdata`=0, stores discarded; → IDLE.
- `per_ack` outside PER_WAIT (late reply after timeout) is ignored.
- In the cycle after any `cpu_ack` the bridge is in IDLE; a request present then starts a new transaction (back-to-back supported).
- Only one outstanding transaction; no buffering of requests.

## Timing
- Reset (async): state IDLE; `cpu_ack`, `bus_error`, `ram_en`, `ram_we`, `per_request`, `per_write` = 0; `cpu_rdata`, `per_address`, `per_wdata`, `error_address` = 0; `per_wstrb` = 0. Reset mid-transaction drops `per_request` immediately; no ack is produced for the aborted access.
- RAM load/store: request sampled cycle N → `cpu_ack` cycle N+1. Throughput 1 access / 2 cycles.
- Peripheral: request at N → `per_request` high from N+1; `per_ack` at cycle M → `cpu_ack` at M+1.
- Timeout: `per_request` high N+1..N+TIMEOUT_CYCLES; `cpu_ack`+`bus_error` at N+TIMEOUT_CYCLES+1.
- Unmapped: request at N → `cpu_ack`+`bus_error` at N+1.

## Test plan
- Store 0xCAFEBABE, wstrb 0xF to 0x00000010, then load 0x00000010 → `ram_addr`=4, `ram_we` pulse once, load ack one cycle after request with `cpu_rdata`=0xCAFEBABE.
- Load 0xE0000004, peripheral acks 3 cycles after `per_request` with 0x12345678 → `per_request` high 3 cycles, `cpu_ack` next cycle with 0x12345678, `bus_error`=0.
- Load 0xE0000008, peripheral never acks, TIMEOUT_CYCLES=8 → `per_request` high exactly 8 cycles, then `cpu_ack`+`bus_error`, `cpu_rdata`=0, `error_address`=0xE0000008; `per_ack` injected 2 cycles later is ignored.
- Load 0x40000000 → ack+`bus_error` one cycle later, rdata 0, no `ram_en`/`per_request` activity.
- Back-to-back RAM loads with request held continuously → acks every second cycle, correct data per address.
- Assert `reset` while in PER_WAIT → `per_request` falls in same cycle, no `cpu_ack`, next request after reset serviced normally.
